usb_rx_bit_decoder: RTL

USB_RX_BIT_DECODER -- requirements
Module: usb_rx_bit_decoder

---
 rtl/usb_rx_bit_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit decoder: DPLL sampling, NRZI decode, unstuffing, EOP.
// Define USB_RX_STUFF_ERR_EN to report a decoded 1 in a stuffed-bit slot on stuff_error.
module usb_rx_bit_decoder (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic rx_enable,
    output logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic eop,
    output logic stuff_error
);

    logic       d_plus_prev;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [2:0] ones_cnt;
    logic       nrzi_ref;
    logic       active;
    logic       in_se0;
    logic       skip;
    logic       byte_pend;

    logic edge_det;
    logic take;
    logic se0;
    logic decoded;
    logic stuffed;

    // A sample landing on an edge cycle covers this bit; skip the one two cycles later.
    always_comb begin
        edge_det = d_plus_sync != d_plus_prev;
        take     = (phase == 2'd2) && (edge_det || !skip);
        se0      = !d_plus_sync && !d_minus_sync;
        decoded  = d_plus_sync == nrzi_ref;
        stuffed  = active && (ones_cnt == 3'd6);
    end

`ifdef USB_RX_STUFF_ERR_EN
    logic serr_q;
    assign stuff_error = serr_q;
`else
    assign stuff_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_plus_prev   <= 1'b1;
            phase         <= 2'd0;
            bit_cnt       <= 3'd0;
            ones_cnt      <= 3'd0;
            nrzi_ref      <= 1'b1;
            active        <= 1'b0;
            in_se0        <= 1'b0;
            skip          <= 1'b0;
            byte_pend     <= 1'b0;
            d_orig        <= 1'b1;
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
            eop           <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            serr_q        <= 1'b0;
`endif
        end else if (!rx_enable) begin
            d_plus_prev   <= d_plus_sync;
            phase         <= 2'd0;
            bit_cnt       <= 3'd0;
            ones_cnt      <= 3'd0;
            nrzi_ref      <= 1'b1;
            active        <= 1'b0;
            in_se0        <= 1'b0;
            skip          <= 1'b0;
            byte_pend     <= 1'b0;
            d_orig        <= 1'b1;
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
            eop           <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            serr_q        <= 1'b0;
`endif
        end else begin
            d_plus_prev   <= d_plus_sync;
            phase         <= edge_det ? 2'd1 : phase + 2'd1;
            shift_enable  <= 1'b0;
            eop           <= 1'b0;
            byte_received <= byte_pend;
            byte_pend     <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            serr_q        <= 1'b0;
`endif
            if (edge_det)
                skip <= phase == 2'd2;
            else if (phase == 2'd2)
                skip <= 1'b0;

            if (take) begin
                if (se0) begin
                    eop      <= !in_se0;
                    in_se0   <= 1'b1;
                    bit_cnt  <= 3'd0;
                    ones_cnt <= 3'd0;
                    nrzi_ref <= 1'b1;
                    active   <= 1'b0;
                end else begin
                    in_se0   <= 1'b0;
                    nrzi_ref <= d_plus_sync;
                    d_orig   <= decoded;
                    // Idle J decodes as 1s; a packet begins at the first K.
                    if (stuffed) begin
                        ones_cnt <= 3'd0;
`ifdef USB_RX_STUFF_ERR_EN
                        serr_q   <= decoded;
`endif
                    end else if (active || !decoded) begin
                        active       <= 1'b1;
                        shift_enable <= 1'b1;
                        bit_cnt      <= bit_cnt + 3'd1;
                        byte_pend    <= bit_cnt == 3'd7;
                        if (!decoded)
                            ones_cnt <= 3'd0;
                        else if (ones_cnt != 3'd6)
                            ones_cnt <= ones_cnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule
